alu_arbiter: RTL and testbench

Shares the single 4-bit combinational ALU between two requesters. Each requester presents an operation with a valid/ready handshake. The arbiter grants one requester at a time in round-robin order, runs the ALU, and registers the result. It then returns the result through a response handshake tagged with the winner's ID. It sits between the two command sources and the `alu` instance it owns.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_arbiter_if.sv | 46 ++++
 rtl/alu.sv | 24 ++
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and datapath width
// for the ALU arbiter slice.
package alu_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response handshake bundle between
// the two command sources, the consumer and the arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int DW = W
);

  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [2:0]    req0_sel;

  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [2:0]    req1_sel;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_y;
  logic          rsp_id;
  logic          rsp_err;
  logic          rsp_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req1_ready,
    input  rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req1_ready,
    output rsp_valid, rsp_y, rsp_id, rsp_err, rsp_zero,
    input  rsp_ready
  );

endinterface

// File: rtl/alu.sv
// Combinational 4-bit ALU; illegal opcodes yield zero.
// Carries and borrows are dropped.
module alu
  import alu_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   sel_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (sel_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_NOT:  y_o = ~a_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two
// requesters, with a registered tagged response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] done_cnt
);

  state_e           state_q, state_d;
  logic             last_id_q;
  logic [W-1:0]     a_q, b_q;
  logic [2:0]       sel_q;
  logic             id_q;
  logic [W-1:0]     y_q;
  logic             err_q, zero_q, rid_q;
  logic [CNT_W-1:0] cnt_q;

  logic         both_v, grant, idle;
  logic         accept, done;
  logic         alu_err;
  logic [W-1:0] alu_y;

  assign both_v = bus.req0_valid & bus.req1_valid;
  assign grant  = both_v ? ~last_id_q : bus.req1_valid;
  assign idle   = (state_q == ST_IDLE) & ~rst;

  assign bus.req0_ready = idle & bus.req0_valid & ~grant;
  assign bus.req1_ready = idle & bus.req1_valid & grant;

  assign accept = bus.req0_ready | bus.req1_ready;
  assign done   = (state_q == ST_RESP) & bus.rsp_ready;

  alu u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .sel_i(sel_q),
    .y_o  (alu_y)
  );

  assign alu_err = sel_q > OP_NOT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_id_q <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      id_q      <= 1'b0;
      y_q       <= '0;
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
      rid_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q       <= grant ? bus.req1_a : bus.req0_a;
        b_q       <= grant ? bus.req1_b : bus.req0_b;
        sel_q     <= grant ? bus.req1_sel : bus.req0_sel;
        id_q      <= grant;
        last_id_q <= grant;
      end
      if (state_q == ST_EXEC) begin
        y_q    <= alu_y;
        err_q  <= alu_err;
        zero_q <= (alu_y == '0);
        rid_q  <= id_q;
      end
      if (done) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_id    = rid_q;
  assign done_cnt      = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a cycle-level
// reference model and literal expectations.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] done_cnt;

  alu_arbiter_if bus ();

  alu_arbiter #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: returns {err, y}
  function automatic int ref_op(int a, int b, int sel);
    case (sel)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return a & b;
      3: return a | b;
      4: return 15 - a;
      default: return 16;
    endcase
  endfunction

  bit m_init  = 0;
  int m_phase = 0;
  int m_last  = 1;
  int m_cnt   = 0;
  int m_a, m_b, m_sel, m_gid;
  int m_y, m_err, m_id;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_last  = 1;
      m_cnt   = 0;
      m_init  = 1;
    end else if (m_init) begin
      case (m_phase)
        0: if (bus.req0_valid || bus.req1_valid) begin
          if (bus.req0_valid && bus.req1_valid)
            m_gid = 1 - m_last;
          else
            m_gid = bus.req1_valid ? 1 : 0;
          m_a   = m_gid ? bus.req1_a : bus.req0_a;
          m_b   = m_gid ? bus.req1_b : bus.req0_b;
          m_sel = m_gid ? bus.req1_sel : bus.req0_sel;
          m_last  = m_gid;
          m_phase = 1;
        end
        1: begin
          m_y   = ref_op(m_a, m_b, m_sel);
          m_err = (m_y == 16) ? 1 : 0;
          if (m_err) m_y = 0;
          m_id    = m_gid;
          m_phase = 2;
        end
        default: if (bus.rsp_ready) begin
          m_cnt   = (m_cnt + 1) % 256;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      bit v0, v1, e0, e1;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      e0 = !rst && m_phase == 0 && v0 && (!v1 || m_last == 1);
      e1 = !rst && m_phase == 0 && v1 && (!v0 || m_last == 0);
      chk("m_req0_ready", bus.req0_ready, e0);
      chk("m_req1_ready", bus.req1_ready, e1);
      chk("m_rsp_valid", bus.rsp_valid, m_phase == 2);
      chk("m_done_cnt", done_cnt, m_cnt);
      if (m_phase == 2) begin
        chk("m_rsp_y", bus.rsp_y, m_y);
        chk("m_rsp_id", bus.rsp_id, m_id);
        chk("m_rsp_err", bus.rsp_err, m_err);
        chk("m_rsp_zero", bus.rsp_zero, m_y == 0);
      end
    end
  end

  int log_id[$];
  int log_y[$];

  always @(negedge clk)
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      log_id.push_back(bus.rsp_id);
      log_y.push_back(bus.rsp_y);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req0_sel = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.req1_sel = 0;
    bus.rsp_ready = 0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_y", bus.rsp_y, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_zero", bus.rsp_zero, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_done_cnt", done_cnt, 0);
    chk("reset_ready0", bus.req0_ready, 0);

    // single ADD 0x9+0x8
    tick();
    rst = 0;
    bus.req0_valid = 1; bus.req0_a = 9; bus.req0_b = 8;
    bus.req0_sel = OP_ADD; bus.rsp_ready = 1;
    @(negedge clk);
    chk("add_ready_same_cycle", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    tick();
    @(negedge clk);
    chk("add_rsp_valid", bus.rsp_valid, 1);
    chk("add_rsp_y", bus.rsp_y, 1);
    chk("add_rsp_id", bus.rsp_id, 0);
    chk("add_rsp_zero", bus.rsp_zero, 0);
    tick();
    @(negedge clk);
    chk("add_done_cnt", done_cnt, 1);
    chk("add_rsp_valid_low", bus.rsp_valid, 0);

    // contention: alternate 0,1,0,1
    rst = 1;
    tick();
    rst = 0;
    log_id.delete();
    log_y.delete();
    bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 5;
    bus.req0_sel = OP_SUB;
    bus.req1_valid = 1; bus.req1_a = 5; bus.req1_b = 0;
    bus.req1_sel = OP_NOT;
    repeat (12) tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("rr_count", log_id.size(), 4);
    if (log_id.size() == 4) begin
      chk("rr_id0", log_id[0], 0);
      chk("rr_y0", log_y[0], 4'hE);
      chk("rr_id1", log_id[1], 1);
      chk("rr_y1", log_y[1], 4'hA);
      chk("rr_id2", log_id[2], 0);
      chk("rr_id3", log_id[3], 1);
    end
    chk("rr_done_cnt", done_cnt, 4);

    // illegal opcode from req1
    bus.req1_valid = 1; bus.req1_a = 3; bus.req1_b = 4;
    bus.req1_sel = 3'b111;
    tick();
    bus.req1_valid = 0;
    tick();
    @(negedge clk);
    chk("ill_rsp_y", bus.rsp_y, 0);
    chk("ill_rsp_err", bus.rsp_err, 1);
    chk("ill_rsp_zero", bus.rsp_zero, 1);
    chk("ill_rsp_id", bus.rsp_id, 1);
    tick();
    @(negedge clk);
    chk("ill_done_cnt", done_cnt, 5);

    // backpressure in RESP
    bus.rsp_ready = 0;
    bus.req0_valid = 1; bus.req0_a = 1; bus.req0_b = 2;
    bus.req0_sel = OP_ADD;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready0_low", bus.req0_ready, 0);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_y", bus.rsp_y, 3);
      tick();
    end
    bus.rsp_ready = 1;
    tick();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("bp_done_cnt", done_cnt, 6);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_no_dup", done_cnt, 6);

    // reset while in EXEC
    bus.req0_valid = 1; bus.req0_a = 2; bus.req0_b = 2;
    tick();
    bus.req0_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_grant0", bus.req0_ready, 1);
    chk("rst_grant1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_after_done", done_cnt, 1);

    // counter wrap over 256 AND ops
    rst = 1;
    tick();
    rst = 0;
    bus.req0_valid = 1;
    bus.req0_sel = OP_AND;
    for (int i = 0; i < 765; i++) begin
      bus.req0_a = 4'($urandom_range(0, 15));
      bus.req0_b = 4'($urandom_range(0, 15));
      tick();
    end
    @(negedge clk);
    chk("wrap_pre", done_cnt, 255);
    repeat (3) tick();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("wrap_zero", done_cnt, 0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
